// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//    Arbitrates the icache refill port and the dcache refill/writeback port onto
//    the single line-wide memory port. One transaction is in flight at a time.
//    I and D are served round-robin, and the memory response is routed back to
//    the side that was granted. A response watchdog and a response-type
//    consistency check raise sticky error flags.
//
// Ports
//    clk, rst           clock; synchronous active-low reset
//    i_req_i/i_addr_i   icache read request (level) and line address
//    i_resp_*_o         icache response pulse and refill line
//    d_req_i/d_we_i     dcache request (level); 1 = writeback, 0 = refill
//    d_addr_i/d_wdata_i dcache address and writeback data
//    d_size_i           dcache access size
//    d_resp_*_o         dcache response pulse and refill line
//    mem_*_o            request side of the memory port (registered)
//    mem_*_i            response side of the memory port
//    err_timeout_o      sticky: memory did not answer within TIMEOUT_CYCLES
//    err_mismatch_o     sticky: response kind/type disagrees with the granted request

package mem_req_arbiter_pkg;
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_LINE = 2'd3
   } access_size_t;
endpackage

module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned LINE_WIDTH     = 128,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_i,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   output logic                  i_resp_valid_o,
   output logic [LINE_WIDTH-1:0] i_resp_data_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [LINE_WIDTH-1:0] d_wdata_i,
   input  access_size_t          d_size_i,
   output logic                  d_resp_valid_o,
   output logic [LINE_WIDTH-1:0] d_resp_data_o,
   output logic                  mem_rd_req_o,
   output logic                  mem_wr_req_o,
   output logic                  mem_is_instr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [LINE_WIDTH-1:0] mem_wdata_o,
   output access_size_t          mem_size_o,
   input  logic                  mem_data_valid_i,
   input  logic                  mem_is_instr_i,
   input  logic [LINE_WIDTH-1:0] mem_data_i,
   input  logic                  mem_wr_done_i,
   output logic                  err_timeout_o,
   output logic                  err_mismatch_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   owner_t                rr_last_q, rr_last_d;
   logic                  we_q, we_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  mem_rd_req_q, mem_rd_req_d;
   logic                  mem_wr_req_q, mem_wr_req_d;
   logic                  mem_is_instr_q, mem_is_instr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   access_size_t          mem_size_q, mem_size_d;

   logic                  i_resp_valid_q, i_resp_valid_d;
   logic [LINE_WIDTH-1:0] i_resp_data_q, i_resp_data_d;
   logic                  d_resp_valid_q, d_resp_valid_d;
   logic [LINE_WIDTH-1:0] d_resp_data_q, d_resp_data_d;

   logic                  err_timeout_q, err_timeout_d;
   logic                  err_mismatch_q, err_mismatch_d;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      rr_last_d      = rr_last_q;
      we_d           = we_q;
      cnt_d          = cnt_q;
      mem_rd_req_d   = mem_rd_req_q;
      mem_wr_req_d   = mem_wr_req_q;
      mem_is_instr_d = mem_is_instr_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_size_d     = mem_size_q;
      i_resp_valid_d = 1'b0;
      i_resp_data_d  = i_resp_data_q;
      d_resp_valid_d = 1'b0;
      d_resp_data_d  = d_resp_data_q;
      err_timeout_d  = err_timeout_q;
      err_mismatch_d = err_mismatch_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_req_i || d_req_i) begin
               // Contention goes to the side not served last; otherwise whoever asks.
               if (i_req_i && d_req_i) begin
                  owner_d = (rr_last_q == OWN_I) ? OWN_D : OWN_I;
               end else begin
                  owner_d = i_req_i ? OWN_I : OWN_D;
               end
               rr_last_d = owner_d;
               if (owner_d == OWN_I) begin
                  we_d        = 1'b0;
                  mem_addr_d  = i_addr_i;
                  mem_wdata_d = '0;
                  mem_size_d  = SZ_LINE;
               end else begin
                  we_d        = d_we_i;
                  mem_addr_d  = d_addr_i;
                  mem_wdata_d = d_wdata_i;
                  mem_size_d  = d_size_i;
               end
               mem_is_instr_d = (owner_d == OWN_I);
               mem_rd_req_d   = !we_d;
               mem_wr_req_d   = we_d;
               cnt_d          = '0;
               state_d        = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (mem_data_valid_i && (mem_is_instr_i != (owner_q == OWN_I))) begin
               err_mismatch_d = 1'b1;
            end
            if ((mem_data_valid_i && we_q) || (mem_wr_done_i && !we_q)) begin
               err_mismatch_d = 1'b1;
            end
            // Any done pulse completes the transaction, even one of the wrong kind,
            // so a misbehaving memory cannot wedge the port.
            if (mem_data_valid_i || mem_wr_done_i) begin
               mem_rd_req_d = 1'b0;
               mem_wr_req_d = 1'b0;
               if (owner_q == OWN_I) begin
                  i_resp_valid_d = 1'b1;
                  i_resp_data_d  = mem_data_i;
               end else begin
                  d_resp_valid_d = 1'b1;
                  d_resp_data_d  = mem_data_i;
               end
               state_d = ST_RESP;
            end else begin
               if (cnt_q != CNT_LIMIT) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (cnt_d == CNT_LIMIT) begin
                  err_timeout_d = 1'b1;
               end
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         owner_q        <= OWN_I;
         rr_last_q      <= OWN_I;
         we_q           <= 1'b0;
         cnt_q          <= '0;
         mem_rd_req_q   <= 1'b0;
         mem_wr_req_q   <= 1'b0;
         mem_is_instr_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_size_q     <= SZ_BYTE;
         i_resp_valid_q <= 1'b0;
         i_resp_data_q  <= '0;
         d_resp_valid_q <= 1'b0;
         d_resp_data_q  <= '0;
         err_timeout_q  <= 1'b0;
         err_mismatch_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         rr_last_q      <= rr_last_d;
         we_q           <= we_d;
         cnt_q          <= cnt_d;
         mem_rd_req_q   <= mem_rd_req_d;
         mem_wr_req_q   <= mem_wr_req_d;
         mem_is_instr_q <= mem_is_instr_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_size_q     <= mem_size_d;
         i_resp_valid_q <= i_resp_valid_d;
         i_resp_data_q  <= i_resp_data_d;
         d_resp_valid_q <= d_resp_valid_d;
         d_resp_data_q  <= d_resp_data_d;
         err_timeout_q  <= err_timeout_d;
         err_mismatch_q <= err_mismatch_d;
      end
   end

   assign i_resp_valid_o = i_resp_valid_q;
   assign i_resp_data_o  = i_resp_data_q;
   assign d_resp_valid_o = d_resp_valid_q;
   assign d_resp_data_o  = d_resp_data_q;
   assign mem_rd_req_o   = mem_rd_req_q;
   assign mem_wr_req_o   = mem_wr_req_q;
   assign mem_is_instr_o = mem_is_instr_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign mem_size_o     = mem_size_q;
   assign err_timeout_o  = err_timeout_q;
   assign err_mismatch_o = err_mismatch_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//    Drives both requesters and plays the memory. A transaction-level model keeps
//    the pending request of each side and the side served last, and predicts the
//    owner, the memory request fields, the response routing and the error flags.
module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 128;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_i;
   logic [AW-1:0] i_addr_i;
   logic          i_resp_valid_o;
   logic [LW-1:0] i_resp_data_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [LW-1:0] d_wdata_i;
   access_size_t  d_size_i;
   logic          d_resp_valid_o;
   logic [LW-1:0] d_resp_data_o;
   logic          mem_rd_req_o;
   logic          mem_wr_req_o;
   logic          mem_is_instr_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wdata_o;
   access_size_t  mem_size_o;
   logic          mem_data_valid_i;
   logic          mem_is_instr_i;
   logic [LW-1:0] mem_data_i;
   logic          mem_wr_done_i;
   logic          err_timeout_o;
   logic          err_mismatch_o;

   mem_req_arbiter #(
      .ADDR_WIDTH    (AW),
      .LINE_WIDTH    (LW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req_i         (i_req_i),
      .i_addr_i        (i_addr_i),
      .i_resp_valid_o  (i_resp_valid_o),
      .i_resp_data_o   (i_resp_data_o),
      .d_req_i         (d_req_i),
      .d_we_i          (d_we_i),
      .d_addr_i        (d_addr_i),
      .d_wdata_i       (d_wdata_i),
      .d_size_i        (d_size_i),
      .d_resp_valid_o  (d_resp_valid_o),
      .d_resp_data_o   (d_resp_data_o),
      .mem_rd_req_o    (mem_rd_req_o),
      .mem_wr_req_o    (mem_wr_req_o),
      .mem_is_instr_o  (mem_is_instr_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_size_o      (mem_size_o),
      .mem_data_valid_i(mem_data_valid_i),
      .mem_is_instr_i  (mem_is_instr_i),
      .mem_data_i      (mem_data_i),
      .mem_wr_done_i   (mem_wr_done_i),
      .err_timeout_o   (err_timeout_o),
      .err_mismatch_o  (err_mismatch_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: pending request per side, and whether D was served last.
   bit            i_pend, d_pend, last_d;
   logic [AW-1:0] exp_i_addr, exp_d_addr;
   logic [LW-1:0] exp_d_wdata;
   bit            exp_d_we;
   access_size_t  exp_d_size;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {i_resp_valid_o, d_resp_valid_o, mem_rd_req_o, mem_wr_req_o,
                            mem_is_instr_o, err_timeout_o, err_mismatch_o, mem_size_o}, '0);
      check({tag, "_addr"}, mem_addr_o, '0);
      check({tag, "_wdata"}, mem_wdata_o, '0);
      check({tag, "_idata"}, i_resp_data_o, '0);
      check({tag, "_ddata"}, d_resp_data_o, '0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_req_i = 1'b0;
      d_req_i = 1'b0;
      mem_data_valid_i = 1'b0;
      mem_wr_done_i = 1'b0;
      mem_is_instr_i = 1'b0;
      tick();
      tick();
      i_pend = 1'b0;
      d_pend = 1'b0;
      last_d = 1'b0;
      check_all_zero("reset");
      rst = 1'b1;
   endtask

   task automatic raise_i(input logic [AW-1:0] a);
      i_req_i = 1'b1;
      i_addr_i = a;
      i_pend = 1'b1;
      exp_i_addr = a;
   endtask

   task automatic raise_d(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                          input access_size_t sz);
      d_req_i = 1'b1;
      d_we_i = we;
      d_addr_i = a;
      d_wdata_i = wd;
      d_size_i = sz;
      d_pend = 1'b1;
      exp_d_we = we;
      exp_d_addr = a;
      exp_d_wdata = wd;
      exp_d_size = sz;
   endtask

   // Serve one transaction. Called in an IDLE cycle with at least one side pending;
   // returns in the IDLE cycle after the response pulse.
   task automatic serve(input int lat, input bit hold, input bit bad_instr, input bit bad_kind);
      bit            own_d;
      bit            rd;
      logic [AW-1:0] a;
      logic [LW-1:0] line;
      access_size_t  sz;
      own_d  = (i_pend && d_pend) ? !last_d : d_pend;
      last_d = own_d;
      rd     = !(own_d && exp_d_we);
      a      = own_d ? exp_d_addr : exp_i_addr;
      sz     = own_d ? exp_d_size : SZ_LINE;
      tick();
      for (int c = 0; c <= lat; c++) begin
         check("mem_req", {mem_rd_req_o, mem_wr_req_o}, {rd, !rd});
         check("is_instr", mem_is_instr_o, !own_d);
         check("addr", mem_addr_o, a);
         check("size", mem_size_o, sz);
         if (!rd) check("wdata", mem_wdata_o, exp_d_wdata);
         check("resp_early", {i_resp_valid_o, d_resp_valid_o}, 2'b00);
         // The granted side's inputs must no longer matter.
         if (own_d) begin
            d_addr_i = $urandom;
            d_wdata_i = rand_line();
         end else begin
            i_addr_i = $urandom;
         end
         if (c < lat) tick();
      end
      line = rand_line();
      mem_data_i = line;
      if (rd ^ bad_kind) begin
         mem_data_valid_i = 1'b1;
         mem_is_instr_i = bad_instr ? own_d : !own_d;
      end else begin
         mem_wr_done_i = 1'b1;
      end
      tick();
      mem_data_valid_i = 1'b0;
      mem_wr_done_i = 1'b0;
      mem_is_instr_i = 1'b0;
      mem_data_i = rand_line();
      check("resp_valid", {i_resp_valid_o, d_resp_valid_o}, {!own_d, own_d});
      check("req_drop", {mem_rd_req_o, mem_wr_req_o}, 2'b00);
      if (rd && !bad_kind) check("resp_data", own_d ? d_resp_data_o : i_resp_data_o, line);
      if (!hold) begin
         if (own_d) d_req_i = 1'b0; else i_req_i = 1'b0;
      end
      tick();
      if (hold) begin
         if (own_d) d_req_i = 1'b0; else i_req_i = 1'b0;
      end
      check("idle_req", {mem_rd_req_o, mem_wr_req_o}, 2'b00);
      check("pulse_once", {i_resp_valid_o, d_resp_valid_o}, 2'b00);
      if (rd && !bad_kind) check("resp_hold", own_d ? d_resp_data_o : i_resp_data_o, line);
      if (own_d) d_pend = 1'b0; else i_pend = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      logic [LW-1:0] line;
      rst = 1'b0;
      i_req_i = 1'b0;
      i_addr_i = '0;
      d_req_i = 1'b0;
      d_we_i = 1'b0;
      d_addr_i = '0;
      d_wdata_i = '0;
      d_size_i = SZ_BYTE;
      mem_data_valid_i = 1'b0;
      mem_is_instr_i = 1'b0;
      mem_data_i = '0;
      mem_wr_done_i = 1'b0;

      do_reset();

      // icache-only read, memory answers after 3 cycles
      raise_i(32'h40);
      serve(3, 1'b0, 1'b0, 1'b0);
      // dcache writeback
      raise_d(1'b1, 32'h100, rand_line(), SZ_LINE);
      serve(2, 1'b0, 1'b0, 1'b0);

      // both at once from reset: D, then I with D asking again, then D
      do_reset();
      raise_i(32'h40);
      raise_d(1'b0, 32'h500, '0, SZ_WORD);
      serve(1, 1'b0, 1'b0, 1'b0);
      raise_d(1'b0, 32'h540, '0, SZ_HALF);
      serve(1, 1'b0, 1'b0, 1'b0);
      serve(1, 1'b0, 1'b0, 1'b0);

      // requester holds req through its response cycle: no second grant
      raise_i(32'h80);
      serve(0, 1'b1, 1'b0, 1'b0);
      tick();
      check("no_dup_grant", {mem_rd_req_o, mem_wr_req_o}, 2'b00);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         if (!i_pend && ($urandom_range(0, 1) == 1)) raise_i($urandom);
         if (!d_pend && ($urandom_range(0, 1) == 1))
            raise_d(1'($urandom_range(0, 1)), $urandom, rand_line(),
                    access_size_t'($urandom_range(0, 3)));
         if (!i_pend && !d_pend) raise_i($urandom);
         serve(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      while (i_pend || d_pend) serve(1, 1'b0, 1'b0, 1'b0);
      check("err_clean", {err_timeout_o, err_mismatch_o}, 2'b00);

      // watchdog: sets exactly after TO busy cycles, late response still completes
      do_reset();
      raise_i(32'hC0);
      tick();
      check("wd_req", mem_rd_req_o, 1'b1);
      check("wd_err_start", err_timeout_o, 1'b0);
      for (int k = 1; k <= int'(TO); k++) begin
         tick();
         check("wd_count", err_timeout_o, (k >= int'(TO)));
      end
      line = rand_line();
      mem_data_i = line;
      mem_data_valid_i = 1'b1;
      mem_is_instr_i = 1'b1;
      tick();
      mem_data_valid_i = 1'b0;
      mem_is_instr_i = 1'b0;
      check("wd_late_resp", i_resp_valid_o, 1'b1);
      check("wd_late_data", i_resp_data_o, line);
      i_req_i = 1'b0;
      i_pend = 1'b0;
      last_d = 1'b0;
      tick();
      check("wd_sticky", {err_timeout_o, err_mismatch_o}, 2'b10);

      // icache read answered as data
      do_reset();
      raise_i(32'h40);
      serve(1, 1'b0, 1'b1, 1'b0);
      check("mismatch_type", {err_timeout_o, err_mismatch_o}, 2'b01);

      // writeback answered with data_valid
      do_reset();
      raise_d(1'b1, 32'h200, rand_line(), SZ_LINE);
      serve(2, 1'b0, 1'b0, 1'b1);
      check("mismatch_kind", {err_timeout_o, err_mismatch_o}, 2'b01);

      // reset in the middle of a transaction, then a fresh request
      do_reset();
      raise_d(1'b0, 32'h600, '0, SZ_WORD);
      tick();
      check("mid_busy", mem_rd_req_o, 1'b1);
      rst = 1'b0;
      tick();
      check_all_zero("mid_reset");
      rst = 1'b1;
      d_req_i = 1'b0;
      i_pend = 1'b0;
      d_pend = 1'b0;
      last_d = 1'b0;
      raise_i(32'h300);
      serve(2, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
